// File: rtl/id_pkg.sv
// Shared constants and types for the instruction-decode stage.
package id_pkg;

    // Register that always reads as zero and ignores writes.
    localparam int ZERO_REG_DEFAULT = 31;

    // Bit of the opaque control bundle that marks a load.
    localparam int CTRL_IS_LOAD_BIT = 0;

    // Default widths, used for the default-width view of the ID/EX register.
    localparam int XLEN_DEFAULT   = 64;
    localparam int AW_DEFAULT     = 5;
    localparam int CTRL_W_DEFAULT = 16;

    // ID/EX pipeline register fields at default widths, for downstream consumers.
    typedef struct packed {
        logic                      valid;
        logic [XLEN_DEFAULT-1:0]   pc;
        logic [XLEN_DEFAULT-1:0]   da;
        logic [XLEN_DEFAULT-1:0]   db;
        logic [XLEN_DEFAULT-1:0]   imm;
        logic [AW_DEFAULT-1:0]     rd;
        logic [CTRL_W_DEFAULT-1:0] ctrl;
    } id_ex_t;

endpackage

// File: rtl/id_stage_pipe_if.sv
// Inbound bundle of the decode stage: IF/ID instruction fields, writeback,
// EX/MEM forwarding buses and downstream pipeline control.
//
// Handshake: id_valid marks a real instruction in IF/ID; that instruction is
// taken into ID/EX at a posedge where stall_if is low, otherwise IF/ID must
// keep presenting it unchanged. Downstream, ex_valid marks a real instruction
// in ID/EX, and ex_stall holds every ID/EX field for as long as it is high.
interface id_stage_pipe_if #(
    parameter int XLEN   = 64,
    parameter int AW     = 5,
    parameter int CTRL_W = 16
);
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [AW-1:0]     id_rn;
    logic [AW-1:0]     id_rm;
    logic [AW-1:0]     id_rd;
    logic              id_reg2loc;
    logic              id_uses_a;
    logic              id_uses_b;
    logic [XLEN-1:0]   id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              wb_we;
    logic [AW-1:0]     wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              ex_fwd_we;
    logic [AW-1:0]     ex_fwd_addr;
    logic [XLEN-1:0]   ex_fwd_data;
    logic              ex_fwd_load;
    logic              mem_fwd_we;
    logic [AW-1:0]     mem_fwd_addr;
    logic [XLEN-1:0]   mem_fwd_data;
    logic              flush;
    logic              ex_stall;

    modport master (
        output id_valid, id_pc, id_rn, id_rm, id_rd, id_reg2loc, id_uses_a,
               id_uses_b, id_imm, id_ctrl, wb_we, wb_addr, wb_data, ex_fwd_we,
               ex_fwd_addr, ex_fwd_data, ex_fwd_load, mem_fwd_we, mem_fwd_addr,
               mem_fwd_data, flush, ex_stall
    );

    modport slave (
        input id_valid, id_pc, id_rn, id_rm, id_rd, id_reg2loc, id_uses_a,
              id_uses_b, id_imm, id_ctrl, wb_we, wb_addr, wb_data, ex_fwd_we,
              ex_fwd_addr, ex_fwd_data, ex_fwd_load, mem_fwd_we, mem_fwd_addr,
              mem_fwd_data, flush, ex_stall
    );
endinterface

// File: rtl/regfile_bypass.sv
// 2-read/1-write register file with a hard-wired zero register and
// writeback write-through, so a same-cycle WB write is visible on the reads.
module regfile_bypass
    import id_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int NREG     = 32,
    parameter int ZERO_REG = ZERO_REG_DEFAULT,
    localparam int AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   ra_a,
    input  logic [AW-1:0]   ra_b,
    output logic [XLEN-1:0] rd_a,
    output logic [XLEN-1:0] rd_b
);
    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    logic [XLEN-1:0] mem [NREG];

    // Array write; the zero register entry is never written and stays 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != ZR) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads: zero register first, then WB write-through, then the array.
    always_comb begin
        rd_a = mem[ra_a];
        rd_b = mem[ra_b];
        if (ra_a == ZR)                 rd_a = '0;
        else if (we && waddr == ra_a)   rd_a = wdata;
        if (ra_b == ZR)                 rd_b = '0;
        else if (we && waddr == ra_b)   rd_b = wdata;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined instruction-decode stage: register read with EX/MEM/WB
// forwarding, load-use hazard detection and a flushable/stallable ID/EX
// register feeding EX. All EX-facing outputs are registered.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int NREG     = 32,
    parameter int ZERO_REG = ZERO_REG_DEFAULT,
    parameter int CTRL_W   = 16,
    parameter int CNT_W    = 16,
    localparam int AW      = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset_n,
    id_stage_pipe_if.slave    bus,
    output logic              stall_if,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_da,
    output logic [XLEN-1:0]   ex_db,
    output logic [XLEN-1:0]   ex_imm,
    output logic [AW-1:0]     ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    // ID/EX register layout at this instance's widths.
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   da;
        logic [XLEN-1:0]   db;
        logic [XLEN-1:0]   imm;
        logic [AW-1:0]     rd;
        logic [CTRL_W-1:0] ctrl;
    } ex_reg_t;

    ex_reg_t         ex_q;
    ex_reg_t         ex_d;
    logic [AW-1:0]   ab;
    logic [XLEN-1:0] rf_a;
    logic [XLEN-1:0] rf_b;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            hazard;

    // Operand forwarding; the register file already covers zero and WB.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] rf_val,
        input logic            ex_ok,
        input logic [AW-1:0]   ex_addr,
        input logic [XLEN-1:0] ex_data,
        input logic            mem_we,
        input logic [AW-1:0]   mem_addr,
        input logic [XLEN-1:0] mem_data
    );
        if (addr == ZR)                          return '0;
        else if (ex_ok && ex_addr == addr)       return ex_data;
        else if (mem_we && mem_addr == addr)     return mem_data;
        else                                     return rf_val;
    endfunction

    // Port B address selection (Reg2Loc).
    always_comb begin
        ab = bus.id_reg2loc ? bus.id_rd : bus.id_rm;
    end

    regfile_bypass #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_rf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (bus.wb_we),
        .waddr   (bus.wb_addr),
        .wdata   (bus.wb_data),
        .ra_a    (bus.id_rn),
        .ra_b    (ab),
        .rd_a    (rf_a),
        .rd_b    (rf_b)
    );

    // Forwarded operands; a loading EX instruction has no data to forward yet.
    always_comb begin
        op_a = fwd_sel(bus.id_rn, rf_a, bus.ex_fwd_we && !bus.ex_fwd_load,
                       bus.ex_fwd_addr, bus.ex_fwd_data, bus.mem_fwd_we,
                       bus.mem_fwd_addr, bus.mem_fwd_data);
        op_b = fwd_sel(ab, rf_b, bus.ex_fwd_we && !bus.ex_fwd_load,
                       bus.ex_fwd_addr, bus.ex_fwd_data, bus.mem_fwd_we,
                       bus.mem_fwd_addr, bus.mem_fwd_data);
    end

    // Load-use hazard and IF stall; flush overrides any stall.
    always_comb begin
        hazard = bus.id_valid && bus.ex_fwd_we && bus.ex_fwd_load &&
                 (bus.ex_fwd_addr != ZR) &&
                 ((bus.id_uses_a && bus.id_rn == bus.ex_fwd_addr) ||
                  (bus.id_uses_b && ab == bus.ex_fwd_addr));
        stall_if = !bus.flush && (bus.ex_stall || hazard);
    end

    // ID/EX next value: flush bubble, then hold, then hazard bubble, then load.
    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d = '0;
        end else if (bus.ex_stall) begin
            ex_d = ex_q;
        end else if (hazard) begin
            ex_d = '0;
        end else begin
            ex_d.valid = bus.id_valid;
            ex_d.pc    = bus.id_pc;
            ex_d.da    = op_a;
            ex_d.db    = op_b;
            ex_d.imm   = bus.id_imm;
            ex_d.rd    = bus.id_rd;
            ex_d.ctrl  = bus.id_valid ? bus.id_ctrl : '0;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ex_q <= '0;
        else          ex_q <= ex_d;
    end

    // Saturating count of cycles lost to load-use hazards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (!bus.flush && !bus.ex_stall && hazard && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign ex_valid = ex_q.valid;
    assign ex_pc    = ex_q.pc;
    assign ex_da    = ex_q.da;
    assign ex_db    = ex_q.db;
    assign ex_imm   = ex_q.imm;
    assign ex_rd    = ex_q.rd;
    assign ex_ctrl  = ex_q.ctrl;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe. A second instance with a 2-bit stall
// counter shares the same inputs and is used only for counter saturation.
module tb_id_stage_pipe;

    logic clk;
    logic reset_n;

    id_stage_pipe_if #(.XLEN(64), .AW(5), .CTRL_W(16)) bus ();

    logic        stall_if;
    logic        ex_valid;
    logic [63:0] ex_pc;
    logic [63:0] ex_da;
    logic [63:0] ex_db;
    logic [63:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [15:0] ex_ctrl;
    logic [15:0] stall_cnt;

    logic        s_stall_if;
    logic        s_ex_valid;
    logic [63:0] s_ex_pc;
    logic [63:0] s_ex_da;
    logic [63:0] s_ex_db;
    logic [63:0] s_ex_imm;
    logic [4:0]  s_ex_rd;
    logic [15:0] s_ex_ctrl;
    logic [1:0]  s_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    id_stage_pipe #(.XLEN(64), .NREG(32), .ZERO_REG(31), .CTRL_W(16), .CNT_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .stall_if  (stall_if),
        .ex_valid  (ex_valid),
        .ex_pc     (ex_pc),
        .ex_da     (ex_da),
        .ex_db     (ex_db),
        .ex_imm    (ex_imm),
        .ex_rd     (ex_rd),
        .ex_ctrl   (ex_ctrl),
        .stall_cnt (stall_cnt)
    );

    id_stage_pipe #(.XLEN(64), .NREG(32), .ZERO_REG(31), .CTRL_W(16), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .stall_if  (s_stall_if),
        .ex_valid  (s_ex_valid),
        .ex_pc     (s_ex_pc),
        .ex_da     (s_ex_da),
        .ex_db     (s_ex_db),
        .ex_imm    (s_ex_imm),
        .ex_rd     (s_ex_rd),
        .ex_ctrl   (s_ex_ctrl),
        .stall_cnt (s_stall_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.id_valid = 0; bus.id_pc = '0; bus.id_rn = '0; bus.id_rm = '0;
        bus.id_rd = '0; bus.id_reg2loc = 0; bus.id_uses_a = 0; bus.id_uses_b = 0;
        bus.id_imm = '0; bus.id_ctrl = '0;
        bus.wb_we = 0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.ex_fwd_we = 0; bus.ex_fwd_addr = '0; bus.ex_fwd_data = '0; bus.ex_fwd_load = 0;
        bus.mem_fwd_we = 0; bus.mem_fwd_addr = '0; bus.mem_fwd_data = '0;
        bus.flush = 0; bus.ex_stall = 0;
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        #2;
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_ex_pc", ex_pc, 64'd0);
        check("rst_ex_da", ex_da, 64'd0);
        check("rst_ex_ctrl", 64'(ex_ctrl), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_stall_if", 64'(stall_if), 64'd0);
        #10 reset_n = 1'b1;
        step();

        // WB write to r5, then read it back through port A.
        bus.wb_we = 1; bus.wb_addr = 5'd5; bus.wb_data = 64'h1234;
        step();
        bus.wb_we = 0;
        bus.id_valid = 1; bus.id_rn = 5'd5; bus.id_uses_a = 1; bus.id_pc = 64'h100;
        bus.id_imm = 64'h7; bus.id_rd = 5'd3; bus.id_ctrl = 16'h00f0;
        step();
        check("rd_ex_da", ex_da, 64'h1234);
        check("rd_ex_valid", 64'(ex_valid), 64'd1);
        check("rd_ex_pc", ex_pc, 64'h100);
        check("rd_ex_imm", ex_imm, 64'h7);
        check("rd_ex_rd", 64'(ex_rd), 64'd3);
        check("rd_ex_ctrl", 64'(ex_ctrl), 64'h00f0);
        check("rd_ex_db_r0", ex_db, 64'd0);

        // Same-cycle WB write seen through the bypass.
        bus.wb_we = 1; bus.wb_addr = 5'd6; bus.wb_data = 64'haaaa; bus.id_rn = 5'd6;
        step();
        check("wb_bypass", ex_da, 64'haaaa);

        // Zero register: same-cycle write and read return 0.
        bus.wb_addr = 5'd31; bus.wb_data = 64'd69; bus.id_rn = 5'd31;
        step();
        check("zero_vs_wb", ex_da, 64'd0);
        bus.wb_we = 0;
        step();
        check("zero_dropped", ex_da, 64'd0);
        bus.ex_fwd_we = 1; bus.ex_fwd_addr = 5'd31; bus.ex_fwd_data = 64'hdead;
        step();
        check("zero_ex_fwd", ex_da, 64'd0);
        bus.ex_fwd_load = 1;
        #1;
        check("zero_no_hazard", 64'(stall_if), 64'd0);
        bus.ex_fwd_we = 0; bus.ex_fwd_load = 0;

        // Forward priority EX > MEM > WB > array.
        bus.id_rn = 5'd8;
        bus.ex_fwd_we = 1; bus.ex_fwd_addr = 5'd8; bus.ex_fwd_data = 64'd1;
        bus.mem_fwd_we = 1; bus.mem_fwd_addr = 5'd8; bus.mem_fwd_data = 64'd2;
        bus.wb_we = 1; bus.wb_addr = 5'd8; bus.wb_data = 64'd3;
        step();
        check("fwd_ex", ex_da, 64'd1);
        bus.ex_fwd_we = 0;
        step();
        check("fwd_mem", ex_da, 64'd2);
        bus.mem_fwd_we = 0;
        step();
        check("fwd_wb", ex_da, 64'd3);
        bus.wb_we = 0;
        step();
        check("fwd_array", ex_da, 64'd3);

        // Load-use on operand B via Reg2Loc.
        bus.id_uses_a = 0; bus.id_uses_b = 1; bus.id_reg2loc = 1; bus.id_rd = 5'd8;
        bus.id_rn = 5'd2; bus.id_rm = 5'd9; bus.id_pc = 64'h200;
        bus.ex_fwd_we = 1; bus.ex_fwd_load = 1; bus.ex_fwd_addr = 5'd8; bus.ex_fwd_data = 64'hbad;
        #1;
        check("lu_stall_if", 64'(stall_if), 64'd1);
        bus.id_uses_b = 0;
        #1;
        check("lu_unused_b", 64'(stall_if), 64'd0);
        bus.id_uses_b = 1; bus.id_valid = 0;
        #1;
        check("lu_invalid", 64'(stall_if), 64'd0);
        bus.id_valid = 1;
        step();
        check("lu_bubble_valid", 64'(ex_valid), 64'd0);
        check("lu_bubble_ctrl", 64'(ex_ctrl), 64'd0);
        check("lu_cnt", 64'(stall_cnt), 64'd1);
        bus.ex_fwd_load = 0; bus.ex_fwd_data = 64'h55;
        #1;
        check("lu_release_if", 64'(stall_if), 64'd0);
        step();
        check("lu_issue_valid", 64'(ex_valid), 64'd1);
        check("lu_issue_db", ex_db, 64'h55);
        check("lu_issue_rd", 64'(ex_rd), 64'd8);
        check("lu_issue_pc", ex_pc, 64'h200);

        // Flush together with hazard.
        bus.ex_fwd_load = 1; bus.flush = 1;
        #1;
        check("fl_hz_stall_if", 64'(stall_if), 64'd0);
        step();
        check("fl_hz_valid", 64'(ex_valid), 64'd0);
        check("fl_hz_cnt", 64'(stall_cnt), 64'd1);

        // Flush together with ex_stall loads a bubble.
        bus.flush = 0; bus.ex_fwd_we = 0; bus.ex_fwd_load = 0;
        step();
        check("fl_st_pre_valid", 64'(ex_valid), 64'd1);
        bus.flush = 1; bus.ex_stall = 1;
        #1;
        check("fl_st_stall_if", 64'(stall_if), 64'd0);
        step();
        check("fl_st_valid", 64'(ex_valid), 64'd0);

        // ex_stall alone holds ID/EX; a hazard under it is not counted.
        bus.flush = 0; bus.ex_stall = 0;
        bus.id_pc = 64'h300; bus.id_imm = 64'h33; bus.id_ctrl = 16'h0a0a;
        step();
        bus.ex_stall = 1; bus.id_pc = 64'h999; bus.id_imm = 64'h99; bus.id_ctrl = 16'h0;
        bus.ex_fwd_we = 1; bus.ex_fwd_load = 1;
        #1;
        check("st_stall_if", 64'(stall_if), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_hold_pc", ex_pc, 64'h300);
            check("st_hold_imm", ex_imm, 64'h33);
            check("st_hold_ctrl", 64'(ex_ctrl), 64'h0a0a);
            check("st_hold_valid", 64'(ex_valid), 64'd1);
        end
        check("st_cnt", 64'(stall_cnt), 64'd1);

        // Asynchronous reset between edges, with a hazard pending.
        #3 reset_n = 1'b0;
        #1;
        check("ar_valid", 64'(ex_valid), 64'd0);
        check("ar_pc", ex_pc, 64'd0);
        check("ar_ctrl", 64'(ex_ctrl), 64'd0);
        check("ar_cnt", 64'(stall_cnt), 64'd0);
        bus.ex_stall = 0; bus.ex_fwd_we = 0; bus.ex_fwd_load = 0;
        #2 reset_n = 1'b1;
        bus.id_reg2loc = 0; bus.id_uses_b = 0; bus.id_uses_a = 1; bus.id_rn = 5'd8;
        bus.id_pc = 64'h400;
        step();
        check("ar_rf_cleared", ex_da, 64'd0);
        check("ar_reissue_pc", ex_pc, 64'h400);
        check("ar_reissue_valid", 64'(ex_valid), 64'd1);

        // Counter saturation: 5 hazard cycles.
        bus.ex_fwd_we = 1; bus.ex_fwd_load = 1; bus.ex_fwd_addr = 5'd8;
        for (int i = 0; i < 3; i++) step();
        check("sat_cnt2_at3", 64'(s_stall_cnt), 64'd3);
        check("sat_cnt16_at3", 64'(stall_cnt), 64'd3);
        for (int i = 0; i < 2; i++) step();
        check("sat_cnt2_at5", 64'(s_stall_cnt), 64'd3);
        check("sat_cnt16_at5", 64'(stall_cnt), 64'd5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
